// File: rtl/arb_pkg.sv
`default_nettype none
// ============================================================================
// Package     : arb_pkg
// Description : Shared definitions for the fetch/data memory port arbiter.
//               FSM state encoding, grant-select encoding, streak width.
// Revision    : 1.0 - initial release
// ============================================================================
package arb_pkg;

    // Arbiter FSM states
    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        BUSY_I = 2'b01,
        BUSY_D = 2'b10
    } state_t;

    // Grant select: which requester wins the current arbitration
    localparam logic GNT_I = 1'b0;
    localparam logic GNT_D = 1'b1;

    // Width of the consecutive-data-grant streak counter
    localparam int STREAK_W = 4;

endpackage : arb_pkg
`default_nettype wire

// File: rtl/arb_priority.sv
`default_nettype none
// ============================================================================
// Module      : arb_priority
// Description : Grant selection between fetch and data requesters. Data wins
//               by default; once STREAK_MAX data grants have been given while
//               a fetch waited, the next contested grant goes to fetch.
// Ports       : clk, reset (async, active-low)
//               i_pend / d_pend : masked pending requests
//               arb_en          : arbitration allowed this cycle (FSM idle)
//               gnt_valid       : a grant is issued this cycle
//               gnt_sel         : GNT_I or GNT_D
// Revision    : 1.0 - initial release
// ============================================================================
module arb_priority
    import arb_pkg::*;
#(
    parameter int STREAK_MAX = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic i_pend,
    input  logic d_pend,
    input  logic arb_en,
    output logic gnt_valid,
    output logic gnt_sel
);

    localparam logic [STREAK_W-1:0] STREAK_LIM = STREAK_W'(STREAK_MAX);

    logic [STREAK_W-1:0] streak;

    always_comb begin
        gnt_valid = arb_en & (i_pend | d_pend);
        gnt_sel   = GNT_D;
        // Fetch wins when it is alone, or when data has used up its streak
        if (i_pend && (!d_pend || (streak == STREAK_LIM))) begin
            gnt_sel = GNT_I;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            streak <= '0;
        end else if (gnt_valid) begin
            if (gnt_sel == GNT_I) begin
                streak <= '0;
            end else if (i_pend) begin
                // Data overtook a waiting fetch: count it, saturating
                streak <= (streak >= STREAK_LIM) ? STREAK_LIM : streak + 1'b1;
            end else begin
                streak <= '0;
            end
        end
    end

endmodule : arb_priority
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter
// Description : Shares one single-port memory between the fetch stage and
//               the memory stage of a pipelined core. Requesters use a
//               req/valid handshake, the memory a req/ready handshake.
// Ports       : clk, reset (async, active-low)
//               i_req/i_addr -> i_rdata/i_valid        fetch port
//               d_req/d_we/d_addr/d_wdata -> d_rdata/d_valid  data port
//               mem_req/mem_we/mem_addr/mem_wdata, mem_rdata/mem_ready
//               stall_f, stall_m : hazard stalls for the core
//               busy             : a memory transaction is outstanding
// Revision    : 1.0 - initial release
// ============================================================================
module mem_port_arbiter
    import arb_pkg::*;
#(
    parameter int AW         = 32,
    parameter int DW         = 32,
    parameter int STREAK_MAX = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_req,
    input  logic [AW-1:0] i_addr,
    output logic [DW-1:0] i_rdata,
    output logic          i_valid,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic [DW-1:0] d_rdata,
    output logic          d_valid,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_ready,
    output logic          stall_f,
    output logic          stall_m,
    output logic          busy
);

    state_t state;
    state_t state_nx;

    logic i_pend;
    logic d_pend;
    logic arb_en;
    logic gnt_valid;
    logic gnt_sel;

    // A requester whose completion pulse is out this cycle is still holding
    // req; masking it keeps the finished request from being re-granted.
    assign i_pend = i_req & ~i_valid;
    assign d_pend = d_req & ~d_valid;
    assign arb_en = (state == IDLE);

    arb_priority #(
        .STREAK_MAX (STREAK_MAX)
    ) u_arb_priority (
        .clk       (clk),
        .reset     (reset),
        .i_pend    (i_pend),
        .d_pend    (d_pend),
        .arb_en    (arb_en),
        .gnt_valid (gnt_valid),
        .gnt_sel   (gnt_sel)
    );

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (gnt_valid) begin
                    state_nx = (gnt_sel == GNT_D) ? BUSY_D : BUSY_I;
                end
            end
            BUSY_I, BUSY_D: begin
                if (mem_ready) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Memory-side latches and requester response registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            i_rdata   <= '0;
            d_rdata   <= '0;
            i_valid   <= 1'b0;
            d_valid   <= 1'b0;
        end else begin
            i_valid <= 1'b0;
            d_valid <= 1'b0;
            if (gnt_valid) begin
                mem_req <= 1'b1;
                if (gnt_sel == GNT_D) begin
                    mem_we    <= d_we;
                    mem_addr  <= d_addr;
                    mem_wdata <= d_wdata;
                end else begin
                    mem_we    <= 1'b0;
                    mem_addr  <= i_addr;
                end
            end else if (mem_ready && (state == BUSY_I)) begin
                mem_req <= 1'b0;
                i_valid <= 1'b1;
                i_rdata <= mem_rdata;
            end else if (mem_ready && (state == BUSY_D)) begin
                mem_req <= 1'b0;
                mem_we  <= 1'b0;
                d_valid <= 1'b1;
                // Stores leave the last load result in place
                if (!mem_we) begin
                    d_rdata <= mem_rdata;
                end
            end
        end
    end

    assign stall_f = i_req & ~i_valid;
    assign stall_m = d_req & ~d_valid;
    assign busy    = (state != IDLE);

endmodule : mem_port_arbiter
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_port_arbiter
// Description : Randomized self-checking bench for mem_port_arbiter. A
//               transaction-level reference model tracks which requester
//               owns the memory, the fairness streak and the expected
//               response registers.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

    localparam int SM = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        i_req;
    logic [31:0] i_addr;
    logic [31:0] i_rdata;
    logic        i_valid;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [31:0] d_rdata;
    logic        d_valid;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ready;
    logic        stall_f;
    logic        stall_m;
    logic        busy;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .AW         (32),
        .DW         (32),
        .STREAK_MAX (SM)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .i_req     (i_req),
        .i_addr    (i_addr),
        .i_rdata   (i_rdata),
        .i_valid   (i_valid),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_rdata   (d_rdata),
        .d_valid   (d_valid),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready),
        .stall_f   (stall_f),
        .stall_m   (stall_m),
        .busy      (busy)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: who owns the memory (0 none, 1 fetch, 2 data)
    int          own;
    int          streak;
    int          wait_left;
    int          n_ifetch;
    int          n_dacc;
    bit          m_req;
    bit          m_we;
    bit          m_iv;
    bit          m_dv;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic [31:0] m_ird;
    logic [31:0] m_drd;
    bit          did_rst;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        assert (act === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, act, exp);
        end
    endtask

    task automatic model_reset();
        own    = 0;
        streak = 0;
        m_req  = 0;
        m_we   = 0;
        m_iv   = 0;
        m_dv   = 0;
        m_addr = '0;
        m_wdata = '0;
        m_ird  = '0;
        m_drd  = '0;
    endtask

    task automatic check_all();
        check("mem_req", mem_req, m_req);
        check("mem_addr", mem_addr, m_addr);
        if (m_req) check("mem_we", mem_we, m_we);
        if (own == 2) check("mem_wdata", mem_wdata, m_wdata);
        check("i_valid", i_valid, m_iv);
        check("d_valid", d_valid, m_dv);
        check("i_rdata", i_rdata, m_ird);
        check("d_rdata", d_rdata, m_drd);
        check("busy", busy, own != 0);
        check("stall_f", stall_f, i_req & ~m_iv);
        check("stall_m", stall_m, d_req & ~m_dv);
    endtask

    // Advance the model across one rising edge using the current inputs
    task automatic model_step();
        bit ip;
        bit dp;
        int g;
        ip   = i_req && !m_iv;
        dp   = d_req && !m_dv;
        m_iv = 0;
        m_dv = 0;
        if (own == 0) begin
            g = 0;
            if (ip && dp)  g = (streak == SM) ? 1 : 2;
            else if (dp)   g = 2;
            else if (ip)   g = 1;
            if (g == 1) streak = 0;
            if (g == 2) streak = ip ? ((streak + 1 > SM) ? SM : streak + 1) : 0;
            if (g != 0) begin
                own       = g;
                m_req     = 1;
                m_addr    = (g == 1) ? i_addr : d_addr;
                m_we      = (g == 2) ? d_we : 1'b0;
                if (g == 2) m_wdata = d_wdata;
                wait_left = $urandom_range(0, 5);
            end
        end else if (mem_ready) begin
            if (own == 1) begin
                m_iv  = 1;
                m_ird = mem_rdata;
                n_ifetch++;
            end else begin
                m_dv = 1;
                if (!m_we) m_drd = mem_rdata;
                n_dacc++;
            end
            own   = 0;
            m_req = 0;
            m_we  = 0;
        end
    endtask

    // Random requester and memory behaviour for the coming cycle
    task automatic drive();
        mem_rdata = $urandom;
        if (own != 0) begin
            mem_ready = (wait_left == 0);
            if (wait_left > 0) wait_left--;
        end else begin
            mem_ready = 1'($urandom_range(0, 1));
        end

        if (m_iv) begin
            i_req = 1'($urandom_range(0, 1));
            if (i_req) i_addr = $urandom;
        end else if (i_req) begin
            if (own != 1) begin
                if ($urandom_range(0, 9) < 2) i_req = 0;
            end else begin
                if ($urandom_range(0, 9) == 0) i_req = 0;
                if ($urandom_range(0, 3) == 0) i_addr = $urandom;
            end
        end else if ($urandom_range(0, 2) == 0) begin
            i_req  = 1;
            i_addr = $urandom;
        end

        if (m_dv) begin
            d_req = 1'($urandom_range(0, 1));
            if (d_req) begin
                d_addr  = $urandom;
                d_wdata = $urandom;
                d_we    = 1'($urandom_range(0, 1));
            end
        end else if (d_req) begin
            if (own != 2) begin
                if ($urandom_range(0, 19) == 0) d_req = 0;
            end else begin
                if ($urandom_range(0, 9) == 0) d_req = 0;
                if ($urandom_range(0, 3) == 0) begin
                    d_addr  = $urandom;
                    d_wdata = $urandom;
                end
            end
        end else if ($urandom_range(0, 1) == 0) begin
            d_req   = 1;
            d_addr  = $urandom;
            d_wdata = $urandom;
            d_we    = 1'($urandom_range(0, 1));
        end
    endtask

    initial begin
        // Reset held with a data request pending: nothing may happen
        reset     = 1'b0;
        i_req     = 1'b0;
        i_addr    = 32'h0000_0100;
        d_req     = 1'b1;
        d_we      = 1'b1;
        d_addr    = 32'h0000_0020;
        d_wdata   = 32'hDEAD_BEEF;
        mem_rdata = 32'hE3A0_0005;
        mem_ready = 1'b0;
        did_rst   = 0;
        n_ifetch  = 0;
        n_dacc    = 0;
        wait_left = 0;
        model_reset();
        repeat (3) begin
            @(negedge clk);
            #1;
            check_all();
        end
        reset = 1'b1;

        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (!did_rst && cyc > 1500 && own == 2) begin
                // Abort an in-flight data access; the held request must be
                // served again afterwards
                did_rst = 1;
                reset   = 1'b0;
                model_reset();
                #1;
                check_all();
                @(negedge clk);
                #1;
                check_all();
                reset = 1'b1;
            end
            drive();
            #1;
            check_all();
            model_step();
            @(negedge clk);
        end

        check("mid_reset_done", did_rst, 1'b1);
        check("fetches_seen", n_ifetch > 50, 1'b1);
        check("data_seen", n_dacc > 50, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_mem_port_arbiter
`default_nettype wire
